// File: rtl/projectile_ctl.sv
// projectile_ctl: frame-stepped ballistic projectile FSM; define PROJ_WIND_EN to add a signed wind input acting on vx
module projectile_ctl #(
   parameter int X_START     = 100,
   parameter int Y_START     = 100,
   parameter int Y_FLOOR     = 30,
   parameter int X_MAX       = 770,
   parameter int GRAVITY     = 1,
   parameter int HOLD_FRAMES = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              throw,
   input  logic [7:0]        vx,
   input  logic signed [9:0] vy,
`ifdef PROJ_WIND_EN
   input  logic signed [3:0] wind,
`endif
   output logic [11:0]       x_pos,
   output logic [11:0]       y_pos,
   output logic              in_flight,
   output logic              landed,
   output logic              oob
);
   typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} state_t;
   localparam logic signed [13:0] YF   = 14'(Y_FLOOR);
   localparam logic signed [13:0] XM   = 14'(X_MAX);
   localparam logic signed [13:0] YC   = 14'sd4095;
   localparam logic signed [10:0] VMIN = -11'sd512;
   localparam logic signed [10:0] G    = 11'(GRAVITY);
   state_t             st_q;
   logic [11:0]        x_q, y_q, nx_c, ny_c;
   logic [7:0]         vx_q, vx_d;
   logic signed [9:0]  vy_q, vy_d;
   logic [15:0]        cnt_q;
   logic               infl_q, land_q, oob_q;
   logic signed [13:0] nx, ny;
   logic signed [10:0] vyd;
`ifdef PROJ_WIND_EN
   logic signed [9:0]  vxw;
`endif
   // candidate position and velocities for the frame being stepped
   always_comb begin
      nx   = $signed({2'b00, x_q}) + $signed({6'b0, vx_q});
      ny   = $signed({2'b00, y_q}) + $signed({{4{vy_q[9]}}, vy_q});
      vyd  = $signed({vy_q[9], vy_q}) - G;
      vy_d = vyd < VMIN ? VMIN[9:0] : vyd[9:0];
      nx_c = nx >= XM ? XM[11:0] : nx[11:0];
      ny_c = ny > YC ? 12'hfff : ny[11:0];
`ifdef PROJ_WIND_EN
      vxw  = $signed({2'b00, vx_q}) + wind;
      vx_d = vxw[9] ? 8'd0 : vxw[8] ? 8'hff : vxw[7:0];
`else
      vx_d = vx_q;
`endif
   end
   // launch, per-frame flight step with floor/edge landing, and post-landing hold
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         x_q    <= 12'(X_START);
         y_q    <= 12'(Y_START);
         vx_q   <= '0;
         vy_q   <= '0;
         cnt_q  <= '0;
         infl_q <= 1'b0;
         land_q <= 1'b0;
         oob_q  <= 1'b0;
      end else begin
         land_q <= 1'b0;
         case (st_q)
            IDLE: if (throw) begin
               vx_q   <= vx;
               vy_q   <= vy;
               infl_q <= 1'b1;
               st_q   <= FLIGHT;
            end
            FLIGHT: if (frame_tick) begin
               x_q <= nx_c;
               if (ny <= YF || nx >= XM) begin
                  y_q    <= ny <= YF ? 12'(Y_FLOOR) : ny_c;
                  oob_q  <= ny > YF;
                  land_q <= 1'b1;
                  infl_q <= 1'b0;
                  st_q   <= LANDED;
               end else begin
                  y_q  <= ny_c;
                  vy_q <= vy_d;
                  vx_q <= vx_d;
               end
            end
            default: if (frame_tick) begin
               if (cnt_q == 16'(HOLD_FRAMES - 1)) begin
                  st_q  <= IDLE;
                  x_q   <= 12'(X_START);
                  y_q   <= 12'(Y_START);
                  oob_q <= 1'b0;
                  cnt_q <= '0;
               end else cnt_q <= cnt_q + 16'd1;
            end
         endcase
      end
   end
   assign x_pos     = x_q;
   assign y_pos     = y_q;
   assign in_flight = infl_q;
   assign landed    = land_q;
   assign oob       = oob_q;
endmodule

// File: tb/tb_projectile_ctl.sv
// tb_projectile_ctl: scoreboard bench with a frame-level reference model of the projectile
module tb_projectile_ctl;
   logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, throw = 1'b0;
   logic [7:0] vx = '0;
   logic signed [9:0] vy = '0;
`ifdef PROJ_WIND_EN
   logic signed [3:0] wind = '0;
`endif
   logic [11:0] x_pos, y_pos;
   logic in_flight, landed, oob;

   projectile_ctl dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .throw(throw), .vx(vx), .vy(vy),
`ifdef PROJ_WIND_EN
      .wind(wind),
`endif
      .x_pos(x_pos), .y_pos(y_pos), .in_flight(in_flight), .landed(landed), .oob(oob)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y; bit l; bit o; bit f;} exp_t;
   exp_t q[$];
   int passed = 0, total = 0;
   int m_ph, m_x, m_y, m_vx, m_vy, m_cnt;
   bit m_oob;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ph = 0; m_x = 100; m_y = 100; m_vx = 0; m_vy = 0; m_cnt = 0; m_oob = 0;
   endtask

   // what one clock edge does to the projectile, in frame terms (0 idle, 1 flying, 2 landed)
   task automatic model_edge(input bit t, input bit f);
      int nx, ny;
      bit l;
      l = 0;
      if (m_ph == 0) begin
         if (t) begin m_vx = vx; m_vy = vy; m_ph = 1; end
      end else if (f && m_ph == 1) begin
         nx = m_x + m_vx;
         ny = m_y + m_vy;
         if (ny <= 30) begin
            m_x = nx < 770 ? nx : 770; m_y = 30; m_oob = 0; m_ph = 2; l = 1;
         end else if (nx >= 770) begin
            m_x = 770; m_y = ny > 4095 ? 4095 : ny; m_oob = 1; m_ph = 2; l = 1;
         end else begin
            m_x = nx;
            m_y = ny > 4095 ? 4095 : ny;
            m_vy = m_vy - 1 < -512 ? -512 : m_vy - 1;
`ifdef PROJ_WIND_EN
            m_vx = m_vx + int'(wind);
            m_vx = m_vx < 0 ? 0 : m_vx > 255 ? 255 : m_vx;
`endif
         end
      end else if (f) begin
         m_cnt++;
         if (m_cnt == 60) model_reset();
      end
      if (f) q.push_back('{x: m_x, y: m_y, l: l, o: m_oob, f: (m_ph == 1)});
   endtask

   task automatic step(input bit t, input bit f);
      @(negedge clk);
      throw = t;
      frame_tick = f;
      model_edge(t, f);
   endtask

   task automatic tick(input int gap);
      step(0, 1);
      repeat (gap) step(0, 0);
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1; throw = 1; frame_tick = 1;
      model_reset();
      @(negedge clk);
      rst = 0; throw = 0; frame_tick = 0;
      chk("rst_x", x_pos, 100);
      chk("rst_y", y_pos, 100);
      chk("rst_in_flight", in_flight, 0);
      chk("rst_landed", landed, 0);
      chk("rst_oob", oob, 0);
   endtask

   // monitor: after each frame tick pop the expected frame result; otherwise outputs must hold still
   initial begin
      bit fs, rs;
      int px, py;
      exp_t e;
      px = 100; py = 100;
      forever begin
         @(posedge clk);
         fs = frame_tick && !rst;
         rs = rst;
         @(negedge clk);
         if (fs) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL sb_empty: output after tick with no expected entry at %0t", $time);
            end else begin
               e = q.pop_front();
               chk("sb_x", x_pos, e.x);
               chk("sb_y", y_pos, e.y);
               chk("sb_landed", landed, e.l);
               chk("sb_oob", oob, e.o);
               chk("sb_in_flight", in_flight, e.f);
            end
         end else if (!rs) begin
            chk("hold_x", x_pos, px);
            chk("hold_y", y_pos, py);
            chk("hold_landed", landed, 0);
         end
         px = x_pos;
         py = y_pos;
      end
   end

   initial begin
      int cnt;
      model_reset();
      repeat (2) @(negedge clk);
      do_rst();
      vx = 5; vy = 10;
      step(1, 0);
      step(0, 0);
      for (int k = 1; k <= 27; k++) begin
         tick(1);
         if (k == 5) step(1, 0);
         if (k == 1) begin chk("t1_x", x_pos, 105); chk("t1_y", y_pos, 110); end
         if (k == 26) chk("t26_y", y_pos, 35);
         if (k == 27) begin chk("t27_x", x_pos, 235); chk("t27_y", y_pos, 30); chk("t27_oob", oob, 0); end
      end
      step(1, 0);
      for (int k = 1; k <= 60; k++) begin
         tick(2);
         if (k == 59) begin chk("hold59_x", x_pos, 235); chk("hold59_in_flight", in_flight, 0); end
         if (k == 60) begin chk("ret_x", x_pos, 100); chk("ret_y", y_pos, 100); chk("ret_oob", oob, 0); end
      end
      vx = 200; vy = 50;
      step(1, 0);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         if (k < 4) chk("edge_x", x_pos, 100 + 200 * k);
         else begin chk("edge_x4", x_pos, 770); chk("edge_oob", oob, 1); end
      end
      repeat (60) tick(1);
      chk("edge_ret_oob", oob, 0);
      vx = 5; vy = 10;
      step(1, 1);
      step(0, 0);
      chk("same_x", x_pos, 100);
      chk("same_y", y_pos, 100);
      chk("same_in_flight", in_flight, 1);
      tick(1);
      chk("same_next_x", x_pos, 105);
      repeat (9) tick(1);
      do_rst();
      repeat (3) step(0, 0);
`ifdef PROJ_WIND_EN
      wind = -2; vx = 5; vy = 10;
      step(1, 0);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         chk("wind_x", x_pos, k == 1 ? 105 : k == 2 ? 108 : 109);
      end
      do_rst();
`endif
      for (int n = 0; n < 12; n++) begin
         vx = n % 3 == 0 ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
         vy = 10'($urandom);
         repeat ($urandom_range(0, 3)) tick(1 + $urandom_range(0, 2));
         step(1, 1'($urandom_range(0, 1)));
         cnt = 0;
         while (m_ph != 0 && cnt < 3000) begin
`ifdef PROJ_WIND_EN
            wind = 4'($urandom);
`endif
            if ($urandom_range(0, 9) == 0) step(1, 0);
            tick(1 + $urandom_range(0, 1));
            cnt++;
         end
         if (m_ph != 0) begin
            total++;
            $display("FAIL flight_bound: flight %0d still active after %0d ticks", n, cnt);
         end
      end
      repeat (3) step(0, 0);
      if (q.size() != 0) begin
         total++;
         $display("FAIL sb_leftover: %0d expected entries never checked", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
